// File: rtl/video_timing_pkg.sv
// Shared types and helpers for the video timing meter: measured-mode tuple,
// lock FSM states and a saturating increment.
package video_timing_pkg;

  localparam int unsigned VT_FIELD_W = 16;

  typedef struct packed {
    logic [VT_FIELD_W-1:0] h_total;
    logic [VT_FIELD_W-1:0] h_active;
    logic [VT_FIELD_W-1:0] v_total;
    logic [VT_FIELD_W-1:0] v_active;
    logic                  hs_pol;
    logic                  vs_pol;
  } timing_t;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} vtm_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/sync_period_counter.sv
// Counts events between boundaries and how many of them saw 'level' high.
// EDGE_OPENS=1: the boundary event starts the new period; 0: it closes the old one.
module sync_period_counter
  import video_timing_pkg::*;
#(
  parameter int unsigned W          = 12,
  parameter bit          EDGE_OPENS = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         adv,
  input  logic         bound,
  input  logic         level,
  output logic [W-1:0] period,
  output logic [W-1:0] level_cnt,
  output logic         done
);

  localparam logic [W-1:0] ONES = '1;

  logic [W-1:0] cnt_q, hi_q, cnt_inc, hi_inc;

  assign cnt_inc = W'(sat_inc(32'(cnt_q), 32'(ONES)));
  assign hi_inc  = W'(sat_inc(32'(hi_q), 32'(ONES)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      period    <= '0;
      level_cnt <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bound) begin
        done <= 1'b1;
        if (EDGE_OPENS) begin
          period    <= cnt_q;
          level_cnt <= hi_q;
          cnt_q     <= W'(1);
          hi_q      <= {{(W-1){1'b0}}, level};
        end else begin
          // a coincident event still belongs to the period being closed
          period    <= adv ? cnt_inc : cnt_q;
          level_cnt <= (adv && level) ? hi_inc : hi_q;
          cnt_q     <= '0;
          hi_q      <= '0;
        end
      end else if (adv) begin
        cnt_q <= cnt_inc;
        if (level) hi_q <= hi_inc;
      end
    end
  end

endmodule

// File: rtl/video_timing_meter.sv
// Measures HS/VS/DE geometry and sync polarity, reports a locked stable mode.
// Optional VTM_FRAME_CLOCKS_EN adds frame_clks (raw clk cycles per frame).
module video_timing_meter
  import video_timing_pkg::*;
#(
  parameter int unsigned CW            = 12,
  parameter int unsigned TIMEOUT_W     = 22,
  parameter int unsigned STABLE_FRAMES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce_pix,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          de,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] h_active,
  output logic [CW-1:0] v_total,
  output logic [CW-1:0] v_active,
  output logic          hs_pol,
  output logic          vs_pol,
  output logic          locked,
  output logic          meas_strobe
`ifdef VTM_FRAME_CLOCKS_EN
  ,
  output logic [TIMEOUT_W-1:0] frame_clks
`endif
);

  localparam logic [CW-1:0] ONES    = '1;
  localparam int unsigned   MW      = $clog2(STABLE_FRAMES + 1);
  localparam logic [MW-1:0] MC_LOCK = MW'(STABLE_FRAMES);

  logic hs_cur, hs_prev, vs_cur, vs_prev, de_cur, smp_vld;
  logic hs_edge, vs_edge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_cur  <= 1'b0;
      hs_prev <= 1'b0;
      vs_cur  <= 1'b0;
      vs_prev <= 1'b0;
      de_cur  <= 1'b0;
      smp_vld <= 1'b0;
    end else begin
      smp_vld <= ce_pix;
      if (ce_pix) begin
        hs_prev <= hs_cur;
        hs_cur  <= hsync;
        vs_prev <= vs_cur;
        vs_cur  <= vsync;
        de_cur  <= de;
      end
    end
  end

  assign hs_edge = smp_vld & hs_cur & ~hs_prev;
  assign vs_edge = smp_vld & vs_cur & ~vs_prev;

  logic [CW-1:0] line_total, line_hi, frame_lines, frame_vs_hi;
  logic          h_done, v_done;

  sync_period_counter #(.W(CW), .EDGE_OPENS(1'b1)) u_hcnt (
    .clk      (clk),
    .reset    (reset),
    .adv      (smp_vld),
    .bound    (hs_edge),
    .level    (hs_cur),
    .period   (line_total),
    .level_cnt(line_hi),
    .done     (h_done)
  );

  sync_period_counter #(.W(CW), .EDGE_OPENS(1'b0)) u_vcnt (
    .clk      (clk),
    .reset    (reset),
    .adv      (hs_edge),
    .bound    (vs_edge),
    .level    (vs_cur),
    .period   (frame_lines),
    .level_cnt(frame_vs_hi),
    .done     (v_done)
  );

  logic [CW-1:0]        de_cnt, h_max, act_cnt, h_max_upd, act_upd;
  logic [CW-1:0]        cand_h_active, cand_v_active;
  logic [TIMEOUT_W-1:0] to_cnt;
  logic                 line_seen, timeout;

  assign h_max_upd = (hs_edge && de_cnt > h_max) ? de_cnt : h_max;
  assign act_upd   = (hs_edge && de_cnt != '0) ? CW'(sat_inc(32'(act_cnt), 32'(ONES))) : act_cnt;
  assign timeout   = (&to_cnt) & ~vs_edge;

  // h_max/act_cnt fold in a coincident line close before the frame snapshot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_cnt        <= '0;
      h_max         <= '0;
      act_cnt       <= '0;
      cand_h_active <= '0;
      cand_v_active <= '0;
      to_cnt        <= '0;
      line_seen     <= 1'b0;
    end else begin
      line_seen <= line_seen | h_done;
      to_cnt    <= vs_edge ? '0 : to_cnt + 1'b1;
      if (smp_vld) begin
        if (hs_edge)     de_cnt <= {{(CW-1){1'b0}}, de_cur};
        else if (de_cur) de_cnt <= CW'(sat_inc(32'(de_cnt), 32'(ONES)));
      end
      if (vs_edge) begin
        cand_h_active <= h_max_upd;
        cand_v_active <= act_upd;
        h_max         <= '0;
        act_cnt       <= '0;
      end else begin
        h_max   <= h_max_upd;
        act_cnt <= act_upd;
      end
    end
  end

  logic fc_ok, fc_sat;
`ifdef VTM_FRAME_CLOCKS_EN
  localparam logic [TIMEOUT_W-1:0] FC_ONES = '1;
  logic [TIMEOUT_W-1:0] fc_cnt, fc_cap, fc_diff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fc_cnt <= '0;
      fc_cap <= '0;
    end else if (vs_edge) begin
      fc_cap <= fc_cnt;
      fc_cnt <= TIMEOUT_W'(1);
    end else begin
      fc_cnt <= TIMEOUT_W'(sat_inc(32'(fc_cnt), 32'(FC_ONES)));
    end
  end

  assign fc_diff = (fc_cap > frame_clks) ? fc_cap - frame_clks : frame_clks - fc_cap;
  assign fc_ok   = fc_diff <= TIMEOUT_W'(1);
  assign fc_sat  = fc_cap == FC_ONES;
`else
  assign fc_ok  = 1'b1;
  assign fc_sat = 1'b0;
`endif

  timing_t cand, cur_q;
  logic    cand_bad, cand_match;

  always_comb begin
    cand          = '0;
    cand.h_total  = VT_FIELD_W'(line_total);
    cand.h_active = VT_FIELD_W'(cand_h_active);
    cand.v_total  = VT_FIELD_W'(frame_lines);
    cand.v_active = VT_FIELD_W'(cand_v_active);
    cand.hs_pol   = {line_hi, 1'b0} > {1'b0, line_total};
    cand.vs_pol   = {frame_vs_hi, 1'b0} > {1'b0, frame_lines};
  end

  assign cand_bad = (line_total == ONES) | (frame_lines == ONES) | (cand_h_active == ONES) |
                    (cand_v_active == ONES) | fc_sat | ~line_seen;
  assign cand_match = (cand == cur_q) & fc_ok;

  vtm_state_t    state_q, state_d;
  logic [MW-1:0] mc_q, mc_d;
  logic          load;

  always_comb begin
    state_d = state_q;
    mc_d    = mc_q;
    load    = 1'b0;
    if (timeout) begin
      state_d = SEARCH;
      mc_d    = '0;
    end else if (v_done) begin
      unique case (state_q)
        SEARCH: begin
          state_d = MEASURE;
          mc_d    = '0;
        end
        MEASURE, LOCKED: begin
          load = 1'b1;
          if (cand_bad) begin
            state_d = MEASURE;
            mc_d    = '0;
          end else if (cand_match && mc_q != '0) begin
            if (state_q == MEASURE) mc_d = mc_q + 1'b1;
            if (mc_d >= MC_LOCK) state_d = LOCKED;
          end else begin
            state_d = MEASURE;
            mc_d    = MW'(1);
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SEARCH;
      mc_q        <= '0;
      meas_strobe <= 1'b0;
      cur_q       <= '0;
    end else begin
      state_q     <= state_d;
      mc_q        <= mc_d;
      meas_strobe <= load;
      if (load) cur_q <= cand;
    end
  end

`ifdef VTM_FRAME_CLOCKS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     frame_clks <= '0;
    else if (load) frame_clks <= fc_cap;
  end
`endif

  assign h_total  = cur_q.h_total[CW-1:0];
  assign h_active = cur_q.h_active[CW-1:0];
  assign v_total  = cur_q.v_total[CW-1:0];
  assign v_active = cur_q.v_active[CW-1:0];
  assign hs_pol   = cur_q.hs_pol;
  assign vs_pol   = cur_q.vs_pol;
  assign locked   = state_q == LOCKED;

endmodule

// File: tb/tb_video_timing_meter.sv
// Directed bench for video_timing_meter: nominal, inverted, gated ce, line change,
// timeout and mid-frame reset, with hand-computed expectations.
module tb_video_timing_meter;
  import video_timing_pkg::*;

  localparam int unsigned CW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ce_pix = 1'b0, hsync = 1'b0, vsync = 1'b0, de = 1'b0;
  logic [CW-1:0] h_total, h_active, v_total, v_active;
  logic          hs_pol, vs_pol, locked, meas_strobe;

  int unsigned n_chk = 0, n_bad = 0;
  int          n_strobe = 0, since = 0, unlock_since = -1, base = 0;
  logic        s_locked = 1'b0, locked_d = 1'b0;

  video_timing_meter #(.CW(CW), .TIMEOUT_W(10), .STABLE_FRAMES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .ce_pix     (ce_pix),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .h_total    (h_total),
    .h_active   (h_active),
    .v_total    (v_total),
    .v_active   (v_active),
    .hs_pol     (hs_pol),
    .vs_pol     (vs_pol),
    .locked     (locked),
    .meas_strobe(meas_strobe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (meas_strobe) begin
      n_strobe = n_strobe + 1;
      s_locked = locked;
      since    = 0;
    end else begin
      since = since + 1;
    end
    if (locked_d && !locked) unlock_since = since;
    locked_d = locked;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ce=0 cycles carry inverted garbage that must be ignored
  task automatic drive_px(input logic h, input logic v, input logic d, input bit alt);
    @(negedge clk);
    ce_pix = 1'b1; hsync = h; vsync = v; de = d;
    if (alt) begin
      @(negedge clk);
      ce_pix = 1'b0; hsync = ~h; vsync = ~v; de = ~d;
    end
  endtask

  task automatic drive_lines(input int unsigned len, input bit inv, input bit alt,
                             input bit hold, input int unsigned y0, input int unsigned y1);
    for (int unsigned y = y0; y < y1; y++) begin
      for (int unsigned x = 0; x < len; x++) begin
        drive_px(logic'(x < 2) ^ inv, (hold ? 1'b0 : logic'(y < 2)) ^ inv,
                 logic'(y >= 2 && y < 8 && x >= 4 && x < 16), alt);
      end
    end
  endtask

  task automatic check_geom(input string tag, input int unsigned ht, input logic pol);
    check_eq({tag, "_h_total"}, 32'(h_total), ht);
    check_eq({tag, "_h_active"}, 32'(h_active), 12);
    check_eq({tag, "_v_total"}, 32'(v_total), 10);
    check_eq({tag, "_v_active"}, 32'(v_active), 6);
    check_eq({tag, "_hs_pol"}, 32'(hs_pol), 32'(pol));
    check_eq({tag, "_vs_pol"}, 32'(vs_pol), 32'(pol));
  endtask

  // three frames after (re)start: no strobe, strobe unlocked, strobe locked
  task automatic lock_seq(input string tag, input bit inv, input bit alt);
    base = n_strobe;
    drive_lines(20, inv, alt, 0, 0, 10);
    check_eq({tag, "_first_vs_strobes"}, 32'(n_strobe - base), 0);
    drive_lines(20, inv, alt, 0, 0, 10);
    check_eq({tag, "_second_strobes"}, 32'(n_strobe - base), 1);
    check_eq({tag, "_second_locked"}, 32'(s_locked), 0);
    drive_lines(20, inv, alt, 0, 0, 10);
    check_eq({tag, "_third_strobes"}, 32'(n_strobe - base), 2);
    check_eq({tag, "_third_locked"}, 32'(s_locked), 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_h_total", 32'(h_total), 0);
    check_eq("rst_v_total", 32'(v_total), 0);
    check_eq("rst_locked", 32'(locked), 0);
    check_eq("rst_strobe", 32'(meas_strobe), 0);
    check_eq("rst_state", 32'(dut.state_q), 32'(SEARCH));
    reset = 1'b0;

    lock_seq("nom", 0, 0);
    check_geom("nom", 20, 1'b0);

    base = n_strobe;
    drive_lines(20, 0, 0, 1, 0, 60);
    check_eq("to_no_strobe", 32'(n_strobe - base), 0);
    check_eq("to_delay_in_window", 32'(unlock_since >= 1016 && unlock_since <= 1032), 1);
    check_eq("to_locked", 32'(locked), 0);
    check_eq("to_state", 32'(dut.state_q), 32'(SEARCH));
    check_eq("to_h_total_held", 32'(h_total), 20);

    lock_seq("relock", 0, 0);

    drive_lines(22, 0, 0, 0, 0, 10);
    check_eq("chg_still_locked", 32'(s_locked), 1);
    base = n_strobe;
    drive_lines(22, 0, 0, 0, 0, 10);
    check_eq("chg_strobe", 32'(n_strobe - base), 1);
    check_eq("chg_h_total", 32'(h_total), 22);
    check_eq("chg_locked", 32'(s_locked), 0);
    drive_lines(22, 0, 0, 0, 0, 10);
    check_eq("chg_relocked", 32'(s_locked), 1);

    drive_lines(20, 0, 0, 0, 0, 5);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_h_total", 32'(h_total), 0);
    check_eq("mid_rst_h_active", 32'(h_active), 0);
    check_eq("mid_rst_v_total", 32'(v_total), 0);
    check_eq("mid_rst_v_active", 32'(v_active), 0);
    check_eq("mid_rst_locked", 32'(locked), 0);
    @(negedge clk);
    reset = 1'b0;
    drive_lines(20, 0, 0, 0, 5, 10);
    lock_seq("inv", 1, 0);
    check_geom("inv", 20, 1'b1);

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    lock_seq("alt", 0, 1);
    check_geom("alt", 20, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/video_timing_meter.md
Name: video_timing_meter

Overview:
- Receiver-side counterpart to the core's video timing generator.
- Samples an HS/VS/DE stream qualified by a pixel enable.
- Measures line and frame geometry and sync polarity, then reports a locked, stable mode.
- Sits on CLK_VIDEO after the video output path; results feed OSD/status and scaler sanity checks.

Parameters:
- CW, 12: width of all pixel and line counters and measurement outputs.
- TIMEOUT_W, 22: clk cycles without a VS rising edge before unlock is 2**TIMEOUT_W.
- STABLE_FRAMES, 2: consecutive identical frame measurements required to assert locked.

Ports:
- clk  in  1  video clock.
- reset  in  1  asynchronous, active-high.
- ce_pix  in  1  pixel enable; HS/VS/DE are sampled only when high.
- hsync  in  1  raw horizontal sync, either polarity.
- vsync  in  1  raw vertical sync, either polarity.
- de  in  1  display enable.
- h_total  out  CW  pixels per line.
- h_active  out  CW  DE pixels per line (maximum over the frame).
- v_total  out  CW  lines per frame.
- v_active  out  CW  lines containing at least one DE pixel.
- hs_pol  out  1  1 = active-low HS.
- vs_pol  out  1  1 = active-low VS.
- locked  out  1  measurements stable.
- meas_strobe  out  1  one-clk pulse when the outputs update.

Behaviour:
- Reset: all outputs 0; all counters 0; FSM in SEARCH.
- Sampling: on ce_pix=1, register hs/vs/de and keep the previous samples. Edge = previous 0, current 1 (raw rising edge for either polarity). With ce_pix=0 nothing advances except the timeout counter.
- Horizontal, per ce_pix:
  - pix_cnt increments and saturates at all-ones.
  - hi_cnt counts hs=1 pixels.
  - de_cnt counts de=1 pixels.
  - On HS edge: line_total = pix_cnt; line_pol = (2*hi_cnt > line_total), computed at CW+1 bits; h_max = max(h_max, de_cnt); line_has_de = (de_cnt != 0). Then pix_cnt = 1, hi_cnt = hs, de_cnt = de (the edge pixel belongs to the new line).
- Vertical:
  - On HS edge: line_cnt++ (saturating); act_cnt++ if line_has_de.
  - vs_hi counts lines sampled with vs=1 at the HS edge.
  - Frame polarity is 2*vs_hi > line_cnt.
- Simultaneous HS and VS edges in the same sample: close the line first, then close the frame, so that line is counted in the ending frame.
- At a VS edge the candidate tuple is {line_total, h_max, line_cnt, act_cnt, line_pol, frame pol}. The vertical accumulators and h_max then clear, and timeout clears.
- FSM:
  - SEARCH: the first VS edge is discarded (partial frame), then go to MEASURE.
  - MEASURE: at each VS edge, compare the candidate with the previous candidate. On a match, match_cnt++; otherwise match_cnt = 1. When match_cnt reaches STABLE_FRAMES, go to LOCKED.
  - LOCKED: a VS edge with a mismatching candidate deasserts locked and goes to MEASURE with match_cnt = 1.
  - Any state: timeout expiry deasserts locked, goes to SEARCH, and leaves outputs holding their last values.
- Output update: measurement outputs load the candidate and meas_strobe pulses on the cycle after every VS edge in MEASURE/LOCKED. locked asserts or deasserts on that same cycle.
- Saturated counters: a saturated counter forces a mismatch and blocks lock.

Optional Feature:
- Macro VTM_FRAME_CLOCKS_EN.
- Defined: add output frame_clks [TIMEOUT_W-1:0], the raw clk cycles between VS edges (independent of ce_pix). It loads with the other outputs and saturates. A difference of more than 1 from the previous frame counts as a mismatch.
- Undefined: no port; comparison uses the tuple only.

Decomposition:
- Package video_timing_pkg:
  - typedef timing_t struct {h_total, h_active, v_total, v_active, hs_pol, vs_pol}.
  - FSM state enum {SEARCH, MEASURE, LOCKED}.
  - Saturating increment function.
- One sub-module, sync_period_counter. Instanced twice: horizontal (event = ce_pix, boundary = HS edge, level = hs) and vertical (event = HS edge, boundary = VS edge, level = vs). It outputs period, level count and a done pulse.

Test Plan:
- Nominal timing, bench at CW=12, TIMEOUT_W=10, ce_pix=1: line 20 px, DE 12 px, HS high 2 px; frame 10 lines, DE on 6 lines, VS high 2 lines. Expect h_total=20, h_active=12, v_total=10, v_active=6, hs_pol=0, vs_pol=0; locked=1 on the cycle after the 3rd VS edge.
- Invert HS and VS (active-low, same widths) -> hs_pol=1, vs_pol=1; all geometry identical.
- ce_pix alternating 1/0 with the same pixel stream -> identical values and lock timing in frames.
- Lock, then change the line to 22 px -> at the next VS edge h_total=22, locked=0, meas_strobe=1; locked=1 again after one more matching frame.
- Lock, then hold vsync constant -> locked=0 after 1024 clks, state SEARCH, h_total still 20.
- Assert reset mid-frame -> all outputs 0 immediately. After release, the first VS edge produces no strobe and lock follows after 3 VS edges.
